// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage register family.
//   skid_state_t   : occupancy state of a skid stage
//                    S_EMPTY - nothing held
//                    S_FULL  - main register holds valid data
//                    S_SKID  - main and skid registers both hold valid data
//   PIPE_DEF_WIDTH : default payload width of a stage
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int PIPE_DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Free-running up counter that stops at its all-ones value instead of
// wrapping. Only an asynchronous reset clears it.
// Ports:
//   clk   in  1  clock
//   rst   in  1  asynchronous active-high reset, clears count
//   inc   in  1  advance the count by one this cycle
//   count out W  current count, saturates at 2^W-1
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;
    logic         w_at_max;

    assign w_at_max = (r_count == {W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Parametrised pipeline stage register with valid/ready handshake, synchronous
// flush and a one-entry skid buffer. in_ready is derived from registered state
// (plus flush/rst) only, so there is no combinational path from out_ready to
// in_ready, yet one transfer per cycle is sustained while out_ready=1.
//
// Optional feature, macro PIPE_STALL_CNT_EN:
//   defined   -> stall_cnt counts cycles with out_valid=1 & out_ready=0,
//                saturating at 2^CNT_W-1, cleared only by rst.
//   undefined -> stall_cnt is tied to 0 and no counter is built.
//
// Parameters:
//   WIDTH     payload width
//   RESET_VAL value loaded into main/skid registers on reset and flush
//   CNT_W     stall counter width
// Ports:
//   clk       in   1      clock
//   rst       in   1      asynchronous active-high reset
//   flush     in   1      synchronous flush, drops held and incoming data
//   in_valid  in   1      upstream has data
//   in_data   in   WIDTH  upstream payload
//   in_ready  out  1      stage accepts data this cycle
//   out_valid out  1      stage holds valid data
//   out_data  out  WIDTH  payload presented downstream (main register)
//   out_ready in   1      downstream accepts data this cycle
//   stall_cnt out  CNT_W  backpressure cycle count
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] stall_cnt
);

    skid_state_t      r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    skid_state_t      w_state_nxt;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_in_fire;
    logic             w_out_fire;

    // Ready depends only on occupancy: the skid slot must be free so that a
    // beat accepted now always has somewhere to land even if the downstream
    // stalls in the same cycle.
    assign w_in_ready  = (r_state != S_SKID) && !flush && !rst;
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_in_fire   = in_valid && w_in_ready;
    assign w_out_fire  = w_out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            // Any out_fire this cycle still completes downstream; everything
            // held or arriving is dropped.
            w_state_nxt = S_EMPTY;
            w_main_nxt  = RESET_VAL;
            w_skid_nxt  = RESET_VAL;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = S_FULL;
                        w_main_nxt  = in_data;
                    end
                end
                S_FULL: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_in_fire) begin
                        // Downstream stalled: park the new beat behind main.
                        w_state_nxt = S_SKID;
                        w_skid_nxt  = in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_SKID: begin
                    // Skid drains into main so ordering is preserved.
                    if (w_out_fire) begin
                        w_state_nxt = S_FULL;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_main  <= RESET_VAL;
            r_skid  <= RESET_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;

`ifdef PIPE_STALL_CNT_EN
    logic w_stall_inc;

    assign w_stall_inc = w_out_valid && !out_ready;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    localparam int          W         = 32;
    localparam int          CW        = 4;
    localparam logic [31:0] RV        = 32'h0;
    localparam int          STALL_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: ordered list of accepted-but-not-delivered beats,
    // capacity two, plus the value currently visible on out_data.
    logic [31:0] q[$];
    logic [31:0] exp_main;
    int          exp_stall;
    logic        last_blocked;

    pipe_skid_reg #(
        .WIDTH     (W),
        .RESET_VAL (RV),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int stall_exp();
`ifdef PIPE_STALL_CNT_EN
        return exp_stall;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        exp_main  = RV;
        exp_stall = 0;
        last_blocked = 1'b0;
    endtask

    // One clock cycle: drive at negedge, compare just after, advance model at posedge.
    task automatic step(input string tag, input logic iv, input logic [31:0] id,
                        input logic ordy, input logic fl);
        logic exp_rdy, ifire, ofire;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = (q.size() < 2) && !fl;
        chk({tag, ".in_ready"},  {31'b0, in_ready},  {31'b0, exp_rdy});
        chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, q.size() > 0});
        chk({tag, ".out_data"},  out_data,           exp_main);
        chk({tag, ".stall_cnt"}, {28'b0, stall_cnt}, stall_exp());
        ifire = iv && exp_rdy;
        ofire = (q.size() > 0) && ordy;
        last_blocked = iv && !exp_rdy;
        if ((q.size() > 0) && !ordy && exp_stall < STALL_MAX) exp_stall++;
        @(posedge clk);
        if (fl) begin
            q.delete();
            exp_main = RV;
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back(id);
            if (q.size() > 0) exp_main = q[0];
        end
    endtask

    // Asynchronous reset pulse placed in the middle of a low clock phase.
    task automatic pulse_rst(input string tag);
        @(negedge clk);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk({tag, ".rst_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".rst_in_ready"},  {31'b0, in_ready},  32'd0);
        chk({tag, ".rst_out_data"},  out_data,           RV);
        chk({tag, ".rst_stall"},     {28'b0, stall_cnt}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, ".rst_hold_ready"}, {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        logic        iv, ordy, fl;
        logic [31:0] id;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        pulse_rst("reset");
        step("post_rst", 1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming
        step("stream0", 1'b1, 32'h11, 1'b1, 1'b0);
        step("stream1", 1'b1, 32'h22, 1'b1, 1'b0);
        step("stream2", 1'b1, 32'h33, 1'b1, 1'b0);
        step("stream3", 1'b0, 32'h0,  1'b1, 1'b0);
        step("stream4", 1'b0, 32'h0,  1'b1, 1'b0);

        // Backpressure into skid, then drain in order
        step("skid0", 1'b1, 32'hA0, 1'b0, 1'b0);
        step("skid1", 1'b1, 32'hA1, 1'b0, 1'b0);
        step("skid2", 1'b0, 32'h0,  1'b0, 1'b0);
        step("drain0", 1'b0, 32'h0, 1'b1, 1'b0);
        step("drain1", 1'b0, 32'h0, 1'b1, 1'b0);
        step("drain2", 1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while skid is full, with a beat offered in the flush cycle
        step("fl_fill0", 1'b1, 32'hB0, 1'b0, 1'b0);
        step("fl_fill1", 1'b1, 32'hB1, 1'b0, 1'b0);
        step("fl_flush", 1'b1, 32'hB2, 1'b0, 1'b1);
        step("fl_after", 1'b0, 32'h0,  1'b1, 1'b0);
        step("fl_after2", 1'b0, 32'h0, 1'b1, 1'b0);

        // Simultaneous fire while full
        step("sim0", 1'b1, 32'hC0, 1'b0, 1'b0);
        step("sim1", 1'b1, 32'hC1, 1'b1, 1'b0);
        step("sim2", 1'b0, 32'h0,  1'b0, 1'b0);
        step("sim3", 1'b0, 32'h0,  1'b1, 1'b0);

        // Long stall: counter saturation, survives flush, cleared by reset
        pulse_rst("stall_rst");
        step("stall_fill", 1'b1, 32'hD0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("stall_hold", 1'b0, 32'h0, 1'b0, 1'b0);
        step("stall_flush", 1'b0, 32'h0, 1'b0, 1'b1);
        step("stall_post", 1'b0, 32'h0, 1'b1, 1'b0);
        pulse_rst("stall_clr");
        step("stall_zero", 1'b0, 32'h0, 1'b1, 1'b0);

        // Randomised traffic honouring the hold-while-blocked rule
        iv = 1'b0; id = '0;
        for (int i = 0; i < 400; i++) begin
            if (!last_blocked) begin
                iv = ($urandom_range(0, 3) != 0);
                id = $urandom;
            end
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 29) == 0);
            step("rand", iv, id, ordy, fl);
        end

        // Reset with data in flight
        step("mid_fill0", 1'b1, 32'hE0, 1'b0, 1'b0);
        step("mid_fill1", 1'b1, 32'hE1, 1'b0, 1'b0);
        pulse_rst("mid_rst");
        step("mid_after", 1'b0, 32'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
